// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue: default bus widths and entry field packing.
package fetch_queue_pkg;

   localparam int unsigned NPC_ADDR_BUS = 32;
   localparam int unsigned NPC_DATA_BUS = 32;

   // Entry layout, LSB first: pvalid, ptaken, ptarget, inst, pc.
   localparam int unsigned PVALID_BIT  = 0;
   localparam int unsigned PTAKEN_BIT  = 1;
   localparam int unsigned PTARGET_LSB = 2;

   function automatic int unsigned inst_lsb(int unsigned aw);
      return aw + 2;
   endfunction

   function automatic int unsigned pc_lsb(int unsigned aw, int unsigned dw);
      return aw + dw + 2;
   endfunction

   function automatic int unsigned entry_width(int unsigned aw, int unsigned dw);
      return 2 * aw + dw + 2;
   endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: synchronous write port, combinational read port.
module fetch_queue_ram #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 98,
   parameter int unsigned PTR_W = 2
) (
   input  logic             i_clock,
   input  logic             i_wr_en,
   input  logic [PTR_W-1:0] i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic [PTR_W-1:0] i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clock) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the fetch pipeline and decode.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue forward its input in the same cycle.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = NPC_ADDR_BUS,
   parameter int unsigned DATA_W = NPC_DATA_BUS
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     valid_pre_i,
   output logic                     ready_pre_o,
   input  logic [ADDR_W-1:0]        pc_i,
   input  logic [DATA_W-1:0]        inst_i,
   input  logic                     pvalid_i,
   input  logic                     ptaken_i,
   input  logic [ADDR_W-1:0]        ptarget_i,
   output logic                     valid_post_o,
   input  logic                     ready_post_i,
   output logic [ADDR_W-1:0]        pc_o,
   output logic [DATA_W-1:0]        inst_o,
   output logic                     pvalid_o,
   output logic                     ptaken_o,
   output logic [ADDR_W-1:0]        ptarget_o,
   input  logic                     flush_i,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned ENT_W = entry_width(ADDR_W, DATA_W);
   localparam int unsigned INST_LSB = inst_lsb(ADDR_W);
   localparam int unsigned PC_LSB = pc_lsb(ADDR_W, DATA_W);

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic             w_ready_pre;
   logic             w_valid_post;
   logic             w_push;
   logic             w_pop;
   logic             w_bypass;
   logic             w_bypass_take;
   logic             w_wr;
   logic             w_rd;
   logic [ENT_W-1:0] w_wr_data;
   logic [ENT_W-1:0] w_rd_data;

   // Full queue refuses pushes even when popping, so ready_pre has no path from ready_post.
   assign w_ready_pre = (r_count != CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
   assign w_bypass = (r_count == '0) && valid_pre_i && !flush_i && !reset;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_bypass_take = w_bypass && ready_post_i;
   assign w_push        = valid_pre_i && w_ready_pre;
   assign w_pop         = w_valid_post && ready_post_i;
   assign w_wr          = w_push && !w_bypass_take;
   assign w_rd          = w_pop && !w_bypass_take;

   assign w_wr_data = {pc_i, inst_i, ptarget_i, ptaken_i, pvalid_i};

   fetch_queue_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W),
      .PTR_W (PTR_W)
   ) u_ram (
      .i_clock   (clock),
      .i_wr_en   (w_wr && !flush_i && !reset),
      .i_wr_addr (r_tail),
      .i_wr_data (w_wr_data),
      .i_rd_addr (r_head),
      .o_rd_data (w_rd_data)
   );

   always_ff @(posedge clock) begin
      if (reset || flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_rd) begin
            r_head <= r_head + PTR_W'(1);
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_valid_post = (r_count != '0);
      pc_o         = w_rd_data[PC_LSB +: ADDR_W];
      inst_o       = w_rd_data[INST_LSB +: DATA_W];
      ptarget_o    = w_rd_data[PTARGET_LSB +: ADDR_W];
      ptaken_o     = w_rd_data[PTAKEN_BIT];
      pvalid_o     = w_rd_data[PVALID_BIT];
      if (w_bypass) begin
         w_valid_post = 1'b1;
         pc_o         = pc_i;
         inst_o       = inst_i;
         ptarget_o    = ptarget_i;
         ptaken_o     = ptaken_i;
         pvalid_o     = pvalid_i;
      end
   end

   assign ready_pre_o  = w_ready_pre;
   assign valid_post_o = w_valid_post;
   assign count_o      = r_count;

endmodule
